// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register placed between CPU stages.
// It carries an opaque DATA_W-bit payload, supports flush, and counts stall cycles.
// Optional feature macro SKID_BUF_EN:
//   - defined: a two-entry skid buffer with a registered in_ready.
//   - undefined (default): a single register with a combinational in_ready.
// While out_valid is low, out_data shows the BUBBLE constant.
module pipe_stage_buf #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The stall counter saturates instead of wrapping, so a long stall never reads as a short one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              push;
  logic              pop;

  assign push = in_valid & in_ready;
  assign pop  = vld_p0 & out_ready;

`ifdef SKID_BUF_EN
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              rdy_q;
  logic              vld_p0_nxt;
  logic              vld_p1_nxt;
  logic              load_p0_in;
  logic              load_p0_skid;
  logic              load_p1;

  // Next-state steering: the skid entry refills main on a pop; otherwise new beats fill main first, then skid.
  always_comb begin
    vld_p0_nxt   = vld_p0;
    vld_p1_nxt   = vld_p1;
    load_p0_in   = 1'b0;
    load_p0_skid = 1'b0;
    load_p1      = 1'b0;
    if (pop) begin
      if (vld_p1) begin
        load_p0_skid = 1'b1;
        vld_p1_nxt   = push;
        load_p1      = push;
      end else if (push) begin
        load_p0_in = 1'b1;
      end else begin
        vld_p0_nxt = 1'b0;
      end
    end else if (push) begin
      if (!vld_p0) begin
        load_p0_in = 1'b1;
        vld_p0_nxt = 1'b1;
      end else begin
        load_p1    = 1'b1;
        vld_p1_nxt = 1'b1;
      end
    end
  end

  // Control state. in_ready is registered from next occupancy, so it has no path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      vld_p0 <= vld_p0_nxt;
      vld_p1 <= vld_p1_nxt;
      rdy_q  <= !(vld_p0_nxt & vld_p1_nxt);
    end
  end

  // Payload registers: no reset is needed, because the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (load_p0_in) begin
      data_p0 <= in_data;
    end else if (load_p0_skid) begin
      data_p0 <= data_p1;
    end
    if (load_p1) begin
      data_p1 <= in_data;
    end
  end

  // rst masks the registered ready, so no beat is taken while the stage is held in reset.
  assign in_ready  = rdy_q & !rst;
  assign occupancy = {vld_p1, vld_p0 & !vld_p1};
`else
  assign in_ready  = !rst & (!vld_p0 | out_ready);
  assign occupancy = {1'b0, vld_p0};

  // Control state. A beat accepted in the same cycle as a pop replaces the old beat, so main stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (push) begin
      vld_p0 <= 1'b1;
    end else if (pop) begin
      vld_p0 <= 1'b0;
    end
  end

  // Payload register: loaded on every accepted beat, and qualified by vld_p0.
  always_ff @(posedge clk) begin
    if (push) begin
      data_p0 <= in_data;
    end
  end
`endif

  // Stall counter: counts cycles where a beat is offered downstream but not taken. Only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (vld_p0 && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = vld_p0 ? data_p0 : BUBBLE;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random checks of pipe_stage_buf.
// The reference model is a FIFO queue with a capacity of 2 when SKID_BUF_EN is defined, and 1 otherwise.
module tb_pipe_stage_buf;
  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] BUB    = 32'h0000_0013;
`ifdef SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              flush = 1'b0;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  int          m_stall = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .BUBBLE(BUB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive the inputs, check in_ready, advance the model across the edge, then check the outputs.
  task automatic cycle(input logic r, input logic iv, input logic [31:0] d,
                       input logic ordy, input logic fl);
    logic rdy_exp;
    logic acc;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    if (SKID) rdy_exp = !r && (q.size() < 2);
    else      rdy_exp = !r && (q.size() == 0 || ordy);
    check("in_ready", in_ready, rdy_exp);
    acc = iv && rdy_exp;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !ordy && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (fl) q.delete();
    end
    #1;
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_data, (q.size() > 0) ? q[0] : BUB);
    check("occupancy", occupancy, q.size());
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  initial begin
    // 1: reset for three cycles while a beat is offered, then the first beat is accepted.
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'hA5A5_0001, 1, 0);
    cycle(0, 1, 32'hA5A5_0001, 1, 0);
    if (SKID) cycle(0, 1, 32'hA5A5_0001, 1, 0);
    check("first_beat", out_data, 32'hA5A5_0001);
    cycle(0, 0, 0, 1, 0);
    // 2: stream eight beats, 1 to 8, with out_ready held high.
    cycle(1, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, i, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // 3: hold beat 7 while beat 8 is offered, then release.
    cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 7, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8, 0, 0);
    check("stall5", stall_cnt, 5);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    // 4: flush while full, with an incoming beat in the same cycle.
    cycle(0, 1, 32'h11, 0, 0);
    cycle(0, 1, 32'h22, 0, 0);
    cycle(0, 1, 32'h33, 1, 1);
    check("flush_bubble", out_data, BUB);
    cycle(0, 0, 0, 1, 0);
    // 5: the stall counter saturates; flush leaves it unchanged and rst clears it.
    cycle(0, 1, 32'h44, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    check("stall_sat", stall_cnt, 15);
    cycle(0, 0, 0, 0, 1);
    check("stall_after_flush", stall_cnt, 15);
    cycle(1, 0, 0, 0, 0);
    check("stall_after_rst", stall_cnt, 0);
    // 6: random valid/ready traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++)
      cycle(($urandom_range(0, 299) == 0), $urandom_range(0, 1), $urandom,
            $urandom_range(0, 1), ($urandom_range(0, 39) == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
